// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game datapath.
// Colour codes, LED/address widths and the receiver state encoding.
package simon_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } colour_t;

    localparam int LED_W  = 10;
    localparam int ADDR_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        REL,
        WAIT,
        DEB,
        FETCH,
        CHECK,
        FIN
    } rx_state_t;

    function automatic colour_t onehot_to_colour(input logic [3:0] v);
        colour_t c;
        case (v)
            4'b0010: c = GREEN;
            4'b0100: c = BLUE;
            4'b1000: c = YELLOW;
            default: c = RED;
        endcase
        return c;
    endfunction

    function automatic logic [LED_W-1:0] colour_led(input colour_t c);
        return {{(LED_W-1){1'b0}}, 1'b1} << c;
    endfunction

endpackage

// File: rtl/stable_timer.sv
// Counts consecutive cycles that a condition holds; expired once it has held N cycles.
// Any cycle without the condition, or a clear, restarts the count. Saturates at N-1.
module stable_timer #(
    parameter longint N  = 2,
    parameter int     CW = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic expired
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt;

    assign expired = hold && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || !hold) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/player_sequence_rx.sv
// Player input receiver: debounces button presses, compares each against the stored
// colour for the current step and reports pass/timeout for the round.
module player_sequence_rx
    import simon_pkg::*;
#(
    parameter int ms          = 1_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int TIMEOUT_MS  = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        level,
    input  logic [3:0]        sw,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout
);

    localparam longint DB_CYC = longint'(DEBOUNCE_MS) * longint'(ms);
    localparam longint TO_CYC = longint'(TIMEOUT_MS) * longint'(ms);
    localparam int     CW     = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

    rx_state_t         state;
    logic [3:0]        level_q;
    logic [3:0]        step;
    colour_t           code;
    logic [3:0]        code_oh;
    logic [CW-1:0]     tcnt;
    logic              capturing;
    logic              sw_onehot;
    logic              tmr_clear;
    logic              tmr_hold;
    logic              stable;
    logic              tmo_hit;

    always_comb begin
        capturing = (state == REL) || (state == WAIT) || (state == DEB);
        sw_onehot = (sw != 4'd0) && ((sw & (sw - 4'd1)) == 4'd0);
        // The debounce timer only runs in REL (waiting for release) and DEB (press held);
        // every other state clears it so each phase starts counting from zero.
        tmr_clear = !((state == REL) || (state == DEB));
        tmr_hold  = (state == REL) ? (sw == 4'd0) : (sw == code_oh);
        tmo_hit   = (tcnt == TO_LAST);
    end

    stable_timer #(
        .N  (DB_CYC),
        .CW (CW)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .hold    (tmr_hold),
        .expired (stable)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_addr <= '0;
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            level_q  <= '0;
            step     <= '0;
            code     <= RED;
            code_oh  <= '0;
            tcnt     <= '0;
        end else begin
            done <= 1'b0;
            // The inter-entry timer has priority over anything seen on sw this cycle.
            if (capturing && tmo_hit) begin
                pass    <= 1'b0;
                timeout <= 1'b1;
                done    <= 1'b1;
                busy    <= 1'b0;
                led     <= '0;
                state   <= FIN;
            end else begin
                if (capturing) begin
                    tcnt <= tcnt + CW'(1);
                end
                case (state)
                    IDLE: begin
                        if (start) begin
                            level_q  <= level;
                            step     <= '0;
                            mem_addr <= '0;
                            pass     <= 1'b0;
                            timeout  <= 1'b0;
                            tcnt     <= '0;
                            led      <= '0;
                            busy     <= 1'b1;
                            state    <= REL;
                        end
                    end
                    REL: begin
                        if (stable) begin
                            led   <= '0;
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (sw_onehot) begin
                            code    <= onehot_to_colour(sw);
                            code_oh <= sw;
                            state   <= DEB;
                        end
                    end
                    DEB: begin
                        if (sw != code_oh) begin
                            state <= WAIT;
                        end else if (stable) begin
                            mem_addr <= step;
                            led      <= colour_led(code);
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= CHECK;
                    end
                    CHECK: begin
                        if (code != colour_t'(mem_data)) begin
                            pass  <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            led   <= '0;
                            state <= FIN;
                        end else if (step == level_q) begin
                            pass  <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            led   <= '0;
                            state <= FIN;
                        end else begin
                            step  <= step + 4'd1;
                            tcnt  <= '0;
                            state <= REL;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_sequence_rx.sv
// Bench for player_sequence_rx: directed vector table, hand-written corner sequences
// and randomized rounds scored against a sequence-scanning reference model.
module tb_player_sequence_rx;

    localparam int N    = 2;
    localparam int T    = 50;
    localparam int MAXT = 1200;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] level;
    logic [3:0] sw;
    logic [3:0] mem_addr;
    logic [1:0] mem_data;
    logic [9:0] led;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    logic [1:0] rom [4];
    logic [3:0] seq [MAXT];
    logic [9:0] led_obs [MAXT];

    typedef struct {
        logic [3:0]  lvl;
        logic [3:0]  pre_val;
        int          pre_len;
        logic [15:0] press;
        int          npress;
        int          exp_t;
        logic        exp_p;
        logic        exp_to;
        int          exp_addr;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= rom[mem_addr[1:0]];

    player_sequence_rx #(
        .ms          (1),
        .DEBOUNCE_MS (N),
        .TIMEOUT_MS  (T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .level    (level),
        .sw       (sw),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .led      (led),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: scan the press sequence (index 0 = first cycle after start) phase by phase.
    function automatic void model(input int lvl, output int t_fin, output logic p, output logic to);
        int t, tclr, step, streak, code;
        logic [3:0] key;
        logic accepted;
        t = 0; tclr = 0; step = 0; t_fin = -1; p = 1'b0; to = 1'b0; key = '0;
        while (t < MAXT) begin
            streak = 0;
            while (streak < N) begin
                if (t >= MAXT) return;
                if (t - tclr == T - 1) begin t_fin = t + 1; to = 1'b1; return; end
                streak = (seq[t] == 4'd0) ? streak + 1 : 0;
                t = t + 1;
            end
            accepted = 1'b0;
            while (!accepted) begin
                if (t >= MAXT) return;
                if (t - tclr == T - 1) begin t_fin = t + 1; to = 1'b1; return; end
                if ($countones(seq[t]) == 1) begin
                    key = seq[t];
                    t = t + 1;
                    streak = 0;
                    while (streak < N) begin
                        if (t >= MAXT) return;
                        if (t - tclr == T - 1) begin t_fin = t + 1; to = 1'b1; return; end
                        if (seq[t] != key) break;
                        streak = streak + 1;
                        t = t + 1;
                    end
                    if (streak == N) accepted = 1'b1;
                    else t = t + 1;
                end else begin
                    t = t + 1;
                end
            end
            code = 0;
            for (int b = 0; b < 4; b++) if (key[b]) code = b;
            // t is now the memory-read cycle; the verdict lands two cycles later
            if (code != int'(rom[step % 4])) begin t_fin = t + 2; return; end
            if (step == lvl) begin t_fin = t + 2; p = 1'b1; return; end
            step = step + 1;
            t = t + 2;
            tclr = t;
        end
    endfunction

    task automatic build_vec(input vec_t v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAXT; i++) seq[i] = 4'd0;
        for (int i = 0; i < v.pre_len; i++) begin seq[idx] = v.pre_val; idx = idx + 1; end
        for (int k = 0; k < v.npress; k++) begin
            idx = idx + 3;
            for (int h = 0; h < 4; h++) begin seq[idx] = v.press[4*k +: 4]; idx = idx + 1; end
        end
    endtask

    task automatic gen_random(input int lvl, input logic noisy);
        int idx, c, nb, h;
        logic [3:0] val;
        idx = 0;
        for (int i = 0; i < MAXT; i++) seq[i] = 4'd0;
        for (int k = 0; k <= lvl; k++) begin
            idx = idx + int'($urandom_range(5, 7));
            c = int'(rom[k % 4]);
            if (noisy && $urandom_range(0, 7) == 0) c = int'($urandom_range(0, 3));
            val = 4'b0001 << c;
            if (noisy && $urandom_range(0, 15) == 0) val = 4'b0101;
            if (noisy && $urandom_range(0, 3) == 0) begin
                nb = int'($urandom_range(1, 3));
                for (int b = 0; b < nb; b++) begin
                    seq[idx] = val; seq[idx + 1] = 4'd0; idx = idx + 2;
                end
            end
            h = noisy ? int'($urandom_range(1, 5)) : int'($urandom_range(3, 5));
            for (int j = 0; j < h; j++) begin seq[idx] = val; idx = idx + 1; end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [3:0] lvl, input int extra_start,
                                 input int exp_t, input logic exp_p, input logic exp_to,
                                 input int exp_addr);
        int t_obs, max_addr;
        logic p_obs, to_obs, busy0;
        t_obs = -1; max_addr = 0; p_obs = 1'b0; to_obs = 1'b0; busy0 = 1'b0;
        @(posedge clk); #1;
        level = lvl; start = 1'b1; sw = seq[0];
        for (int t = 0; t < MAXT; t++) begin
            @(posedge clk); #1;
            start = (t == extra_start);
            sw    = seq[t];
            level = 4'($urandom);
            @(negedge clk);
            led_obs[t] = led;
            if (t == 0) busy0 = busy;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (done) begin
                t_obs = t; p_obs = pass; to_obs = timeout;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; sw = 4'd0;
        @(negedge clk);
        check({tag, "_done_cycle"}, t_obs, exp_t);
        check({tag, "_pass"}, {31'd0, p_obs}, {31'd0, exp_p});
        check({tag, "_timeout"}, {31'd0, to_obs}, {31'd0, exp_to});
        check({tag, "_busy_first"}, {31'd0, busy0}, 32'd1);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_after"}, {31'd0, done}, 32'd0);
        check({tag, "_pass_held"}, {31'd0, pass}, {31'd0, exp_p});
        check({tag, "_timeout_held"}, {31'd0, timeout}, {31'd0, exp_to});
        if (exp_addr >= 0) check({tag, "_max_addr"}, max_addr, exp_addr);
    endtask

    initial begin
        int   m_t;
        logic m_p, m_to, seen_done;
        int   lvl;

        rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd3; rom[3] = 2'd1;

        vecs[0] = '{4'd3, 4'd0,    0,   16'h2814, 4, 29, 1'b1, 1'b0, 3};
        vecs[1] = '{4'd3, 4'd0,    0,   16'h0024, 2, 15, 1'b0, 1'b0, 1};
        vecs[2] = '{4'd0, 4'd0,    0,   16'h0004, 1, 8,  1'b1, 1'b0, 0};
        vecs[3] = '{4'd0, 4'd0,    0,   16'h0008, 1, 8,  1'b0, 1'b0, 0};
        vecs[4] = '{4'd0, 4'd0,    0,   16'h0000, 0, 50, 1'b0, 1'b1, 0};
        vecs[5] = '{4'd0, 4'b0011, 300, 16'h0000, 0, 50, 1'b0, 1'b1, 0};
        vecs[6] = '{4'd0, 4'b0001, 5,   16'h0004, 1, 13, 1'b1, 1'b0, 0};
        vecs[7] = '{4'd1, 4'd0,    0,   16'h0004, 1, 58, 1'b0, 1'b1, 0};
        vecs[8] = '{4'd0, 4'd0,    46,  16'h0004, 1, 50, 1'b0, 1'b1, 0};

        reset = 1'b1; start = 1'b0; level = 4'd0; sw = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check("rst_led", {22'd0, led}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            build_vec(vecs[v]);
            run_and_check($sformatf("vec%0d", v), vecs[v].lvl, -1, vecs[v].exp_t,
                          vecs[v].exp_p, vecs[v].exp_to, vecs[v].exp_addr);
        end

        // start pulses while busy and in the done cycle are both ignored
        build_vec(vecs[0]);
        run_and_check("start_busy", 4'd3, 5, 29, 1'b1, 1'b0, 3);
        build_vec(vecs[2]);
        run_and_check("start_at_done", 4'd0, 8, 8, 1'b1, 1'b0, 0);

        // bounce: 0100/0000 toggling, then held; only one step accepted
        for (int i = 0; i < MAXT; i++) seq[i] = (i >= 2 && (i >= 6 || i % 2 == 0)) ? 4'b0100 : 4'd0;
        run_and_check("bounce", 4'd1, -1, 61, 1'b0, 1'b1, 0);
        check("bounce_led_during", {22'd0, led_obs[5]}, 32'd0);
        check("bounce_led_held", {22'd0, led_obs[20]}, 32'h4);
        check("bounce_led_fin", {22'd0, led_obs[61]}, 32'd0);

        // reset in the middle of a round
        build_vec(vecs[0]);
        seen_done = 1'b0;
        @(posedge clk); #1;
        level = 4'd3; start = 1'b1; sw = seq[0];
        for (int t = 0; t <= 16; t++) begin
            @(posedge clk); #1;
            start = 1'b0; sw = seq[t];
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("midrst_addr_before", {28'd0, mem_addr}, 32'd1);
        check("midrst_led_before", {22'd0, led}, 32'h1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; sw = 4'd0;
        @(negedge clk);
        if (done) seen_done = 1'b1;
        check("midrst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check("midrst_led", {22'd0, led}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_pass", {31'd0, pass}, 32'd0);
        check("midrst_timeout", {31'd0, timeout}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("midrst_no_done", {31'd0, seen_done}, 32'd0);
        build_vec(vecs[0]);
        run_and_check("after_rst", 4'd3, -1, 29, 1'b1, 1'b0, 3);

        // randomized rounds against the reference model
        for (int r = 0; r < 30; r++) begin
            lvl = (r == 0) ? 15 : int'($urandom_range(0, 15));
            gen_random(lvl, r != 0);
            model(lvl, m_t, m_p, m_to);
            run_and_check($sformatf("rnd%0d", r), 4'(lvl), int'($urandom_range(0, 80)),
                          m_t, m_p, m_to, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
